led_scan_monitor: RTL and testbench
===================================

// Module: led_scan_monitor
// PURPOSE
//  Receive-side checker for the 8-LED bouncing-bar display driver. Samples the LED bus on a
//  strobe, classifies each frame, and tracks bar position and sweep direction.
//  Flags illegal frames and illegal jumps, and counts direction reversals and errors.
//  Sits beside the LED driver in the example top; its outputs go to status regs/ILA.
// PARAMETERS
//  LOCK_FRAMES  4   consecutive legal moves required to enter LOCKED (1..15)
//  CNT_W        16  width of sweep_cnt and err_cnt
// PORTS
//  clk        in   1      system clock; all logic on posedge
//  rst        in   1      asynchronous, active-high reset
//  led_in     in   8      LED bus under observation; bit 0 = LED0
//  sample_en  in   1      frame strobe; led_in is captured on cycles where this is 1
//  locked     out  1      1 = pattern tracked and consistent
//  pos2       out  4      bar centroid in half-LED units (0..14)
//  dir        out  1      0 = moving toward LED7 (pos2 rising), 1 = toward LED0
//  sweep_cnt  out  CNT_W  direction reversals seen while LOCKED; saturates at all-ones
//  err_cnt    out  CNT_W  errors seen while LOCKED; saturates at all-ones
//  err_stb    out  1      one-cycle pulse per detected error (in any state)
// BEHAVIOUR
//  Reset (async, any cycle): all outputs 0. State=UNLOCKED. Pipeline valid bits, reference pos2, and lock count are cleared.
//  Stage S1: on sample_en, register led_in and set v1. v1 is cleared otherwise.
//  Stage S2: classify the S1 frame.
//   - Legal frame: exactly one 1, at index i (pos2=2i), or exactly two adjacent 1s, at i,i+1 (pos2=2i+1).
//   - Any other frame is illegal, including 8'h00, two or more separated 1s, and three or more 1s.
//  Stage S3: compare the frame with ref_pos2, the last legal pos2.
//   - delta = new - ref. This is a 5-bit signed subtract; no wrap.
//   - |delta| in {1,2}: legal move. dir_new = (delta<0).
//   - delta = 0: stall. Legal, but counts nothing and leaves dir unchanged.
//   - |delta| >= 3 or an illegal frame: error.
//  Latency: a frame sampled at cycle N updates pos2/dir/locked/err_stb at N+2. Counters update at N+2 as well.
//  Back-to-back sample_en is allowed; the pipeline accepts one frame per clk.
//  FSM states:
//   UNLOCKED: first legal frame loads ref_pos2 and pos2, clears lock count, and goes to ACQUIRE.
//   ACQUIRE: each legal move does lock count +1 and updates ref/pos2/dir. When the count reaches LOCK_FRAMES, go to LOCKED.
//   ACQUIRE, error: err_stb=1, lock count=0, ref reloaded if the frame is legal, otherwise go to UNLOCKED. err_cnt is not incremented.
//   LOCKED: each legal move updates ref/pos2/dir. If dir_new != dir, sweep_cnt +1.
//   LOCKED, error: err_stb=1, err_cnt +1, locked->0, go to UNLOCKED. pos2/dir hold their last good values.
//  In UNLOCKED, an illegal frame pulses err_stb only.
//  Simultaneous events:
//   - Error and lock threshold on the same frame: error wins, and the block does not lock.
//   - Reversal on the frame that reaches lock: not counted; the state is still ACQUIRE at evaluation.
//  Saturation: counters hold at 2^CNT_W-1. err_stb still pulses.
//  A frame in flight when rst asserts is discarded.
//  sample_en high during rst is ignored.
// STRUCTURE
//  Package led_scan_pkg holds the FSM state encoding (UNLOCKED/ACQUIRE/LOCKED), LED_N=8, and POS2_W=4.
//  Sub-module led_frame_classify is purely combinational: in [7:0] -> legal, pos2[3:0]. It is instanced in S2.
//  The top holds the S1/S2 registers, delta compare, FSM and counters.
// TESTING
//  1) Reset, then 5 strobes: 01,03,06,0C,18.
//     -> locked=1 two cycles after the 5th strobe; pos2=7, dir=0, err_cnt=0.
//  2) Locked sweep 40,C0,80,C0 (pos2 12,13,14,13).
//     -> dir flips to 1 at the last frame; sweep_cnt=1.
//  3) Locked, then 0x18 followed by 0x81.
//     -> err_stb one pulse, err_cnt=1, locked=0; pos2 holds 7.
//  4) Locked at pos2=7, then a jump to 0xC0 (pos2 13).
//     -> error as in 3; next legal frames re-lock after LOCK_FRAMES moves.
//  5) Repeat the same frame 0x06 ten times while locked.
//     -> no error, counters unchanged, locked stays 1.
//  6) Force err_cnt to all-ones (CNT_W=2), then inject an error.
//     -> err_cnt stays 3 and err_stb still pulses.
//  7) Assert rst mid-pipeline (one cycle after a strobe).
//     -> all outputs 0 immediately, and the in-flight frame never appears.

Source files
------------

// File: rtl/led_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_scan_pkg
// Description : Shared constants for the LED scan monitor: LED bus width,
//               centroid width, FSM state encoding and a centroid helper.
// Revision    : 1.0 - initial release
// ============================================================================
package led_scan_pkg;

  // LED bus and centroid geometry
  localparam int LED_N  = 8;
  localparam int POS2_W = 4;
  localparam int IDX_W  = 3;

  // Tracking FSM encoding
  localparam logic [1:0] ST_UNLOCKED = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  // Centroid in half-LED units: a single LED i sits at 2i and an adjacent
  // pair (i, i+1) sits halfway between them at 2i+1.
  function automatic logic [POS2_W-1:0] pos2_of(input logic [IDX_W-1:0] idx,
                                                input logic             pair);
    return {idx, pair};
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_frame_classify.sv
`default_nettype none
// ============================================================================
// Module      : led_frame_classify
// Description : Purely combinational frame classifier. A frame is legal when
//               it holds exactly one lit LED, or exactly two adjacent lit
//               LEDs. Every other pattern (blank, separated, three or more)
//               is illegal.
// Ports       : frame_in [7:0] in  - LED frame, bit 0 = LED0
//               legal          out - 1 when the frame is a legal bar
//               pos2     [3:0] out - bar centroid in half-LED units (0 when
//                                    the frame is illegal)
// Revision    : 1.0 - initial release
// ============================================================================
module led_frame_classify
  import led_scan_pkg::*;
(
  input  logic [LED_N-1:0]  frame_in,
  output logic              legal,
  output logic [POS2_W-1:0] pos2
);

  localparam logic [LED_N-1:0] c_single = LED_N'(1);
  localparam logic [LED_N-1:0] c_pair   = LED_N'(3);
  localparam logic [IDX_W-1:0] c_top    = IDX_W'(LED_N - 1);

  logic [IDX_W-1:0] low_idx;
  logic             found;
  logic             is_single;
  logic             is_pair;

  always_comb begin
    low_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < LED_N; i++) begin
      if (frame_in[i] && !found) begin
        low_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end

    // Matching the whole frame against a shifted template rejects any stray
    // extra bits. The pair template is excluded at the top index because its
    // upper bit would fall off the bus and alias with a single LED7.
    is_single = (frame_in == (c_single << low_idx));
    is_pair   = (low_idx != c_top) && (frame_in == (c_pair << low_idx));

    legal = is_single || is_pair;
    pos2  = legal ? pos2_of(low_idx, is_pair) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/led_scan_monitor.sv
`default_nettype none
// ============================================================================
// Module      : led_scan_monitor
// Description : Receive-side checker for the 8-LED bouncing-bar driver.
//               S1 captures the LED bus on sample_en, S2 classifies the
//               frame, S3 compares it with the last legal centroid and runs
//               the UNLOCKED/ACQUIRE/LOCKED tracking FSM and counters.
//               A frame captured on edge N is reflected on edge N+2.
// Ports       : clk             in  - system clock, posedge
//               rst             in  - asynchronous active-high reset
//               led_in    [7:0] in  - LED bus under observation
//               sample_en       in  - frame strobe
//               locked          out - pattern tracked and consistent
//               pos2      [3:0] out - last good bar centroid (half-LED units)
//               dir             out - 0 = toward LED7, 1 = toward LED0
//               sweep_cnt [W-1] out - reversals while LOCKED (saturating)
//               err_cnt   [W-1] out - errors while LOCKED (saturating)
//               err_stb         out - one-cycle pulse per detected error
// Revision    : 1.0 - initial release
// ============================================================================
module led_scan_monitor
  import led_scan_pkg::*;
#(
  parameter int LOCK_FRAMES = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LED_N-1:0]  led_in,
  input  logic              sample_en,
  output logic              locked,
  output logic [POS2_W-1:0] pos2,
  output logic              dir,
  output logic [CNT_W-1:0]  sweep_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_stb
);

  localparam logic [3:0]       c_lock_target = 4'(LOCK_FRAMES);
  localparam logic [CNT_W-1:0] c_cnt_max     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one     = CNT_W'(1);

  // --------------------------------------------------------------------------
  // Pipeline and tracking state
  // --------------------------------------------------------------------------
  logic [LED_N-1:0]  frame1_q,   frame1_d;
  logic              v1_q,       v1_d;
  logic              v2_q,       v2_d;
  logic              legal2_q,   legal2_d;
  logic [POS2_W-1:0] fpos2_q,    fpos2_d;
  logic [1:0]        state_q,    state_d;
  logic [POS2_W-1:0] ref_pos2_q, ref_pos2_d;
  logic [3:0]        lock_cnt_q, lock_cnt_d;
  logic [POS2_W-1:0] pos2_q,     pos2_d;
  logic              dir_q,      dir_d;
  logic [CNT_W-1:0]  sweep_q,    sweep_d;
  logic [CNT_W-1:0]  err_q,      err_d;
  logic              stb_q,      stb_d;

  logic              cls_legal;
  logic [POS2_W-1:0] cls_pos2;

  // --------------------------------------------------------------------------
  // S1: capture. The valid bit only follows the strobe so a stale frame is
  // never re-evaluated.
  // --------------------------------------------------------------------------
  always_comb begin
    frame1_d = sample_en ? led_in : frame1_q;
    v1_d     = sample_en;
  end

  // --------------------------------------------------------------------------
  // S2: classify
  // --------------------------------------------------------------------------
  led_frame_classify u_classify (
    .frame_in (frame1_q),
    .legal    (cls_legal),
    .pos2     (cls_pos2)
  );

  always_comb begin
    v2_d     = v1_q;
    legal2_d = v1_q ? cls_legal : legal2_q;
    fpos2_d  = v1_q ? cls_pos2  : fpos2_q;
  end

  // --------------------------------------------------------------------------
  // S3: move evaluation against the reference centroid
  // --------------------------------------------------------------------------
  logic [POS2_W:0] delta;
  logic [POS2_W:0] delta_mag;
  logic            delta_neg;
  logic            is_stall;
  logic            is_move;
  logic            is_err;
  logic [CNT_W-1:0] sweep_inc;
  logic [CNT_W-1:0] err_inc;

  always_comb begin
    // One extra bit keeps the subtraction signed without wrap: 0..14 minus
    // 0..14 always fits in -14..+14.
    delta     = {1'b0, fpos2_q} - {1'b0, ref_pos2_q};
    delta_neg = delta[POS2_W];
    delta_mag = delta_neg ? ((POS2_W+1)'(0) - delta) : delta;
    is_stall  = (delta == '0);
    is_move   = (delta_mag == (POS2_W+1)'(1)) || (delta_mag == (POS2_W+1)'(2));
    is_err    = !legal2_q || (!is_stall && !is_move);
    sweep_inc = (sweep_q == c_cnt_max) ? sweep_q : sweep_q + c_cnt_one;
    err_inc   = (err_q   == c_cnt_max) ? err_q   : err_q   + c_cnt_one;
  end

  // --------------------------------------------------------------------------
  // Tracking FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    ref_pos2_d = ref_pos2_q;
    lock_cnt_d = lock_cnt_q;
    pos2_d     = pos2_q;
    dir_d      = dir_q;
    sweep_d    = sweep_q;
    err_d      = err_q;
    stb_d      = 1'b0;

    if (v2_q) begin
      case (state_q)
        ST_UNLOCKED: begin
          // The first legal frame has nothing to be compared with; it simply
          // seeds the reference.
          if (legal2_q) begin
            ref_pos2_d = fpos2_q;
            pos2_d     = fpos2_q;
            lock_cnt_d = '0;
            state_d    = ST_ACQUIRE;
          end else begin
            stb_d = 1'b1;
          end
        end

        ST_ACQUIRE: begin
          if (is_err) begin
            stb_d      = 1'b1;
            lock_cnt_d = '0;
            if (legal2_q) begin
              ref_pos2_d = fpos2_q;
            end else begin
              state_d = ST_UNLOCKED;
            end
          end else if (is_move) begin
            // Reversals are not counted here, including on the frame that
            // reaches the lock threshold.
            ref_pos2_d = fpos2_q;
            pos2_d     = fpos2_q;
            dir_d      = delta_neg;
            lock_cnt_d = lock_cnt_q + 4'd1;
            if ((lock_cnt_q + 4'd1) == c_lock_target) begin
              state_d = ST_LOCKED;
            end
          end
        end

        ST_LOCKED: begin
          if (is_err) begin
            // pos2/dir keep their last good values for the status readout.
            stb_d   = 1'b1;
            err_d   = err_inc;
            state_d = ST_UNLOCKED;
          end else if (is_move) begin
            ref_pos2_d = fpos2_q;
            pos2_d     = fpos2_q;
            dir_d      = delta_neg;
            if (delta_neg != dir_q) begin
              sweep_d = sweep_inc;
            end
          end
        end

        default: begin
          state_d = ST_UNLOCKED;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame1_q   <= '0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      legal2_q   <= 1'b0;
      fpos2_q    <= '0;
      state_q    <= ST_UNLOCKED;
      ref_pos2_q <= '0;
      lock_cnt_q <= '0;
      pos2_q     <= '0;
      dir_q      <= 1'b0;
      sweep_q    <= '0;
      err_q      <= '0;
      stb_q      <= 1'b0;
    end else begin
      frame1_q   <= frame1_d;
      v1_q       <= v1_d;
      v2_q       <= v2_d;
      legal2_q   <= legal2_d;
      fpos2_q    <= fpos2_d;
      state_q    <= state_d;
      ref_pos2_q <= ref_pos2_d;
      lock_cnt_q <= lock_cnt_d;
      pos2_q     <= pos2_d;
      dir_q      <= dir_d;
      sweep_q    <= sweep_d;
      err_q      <= err_d;
      stb_q      <= stb_d;
    end
  end

  assign locked    = (state_q == ST_LOCKED);
  assign pos2      = pos2_q;
  assign dir       = dir_q;
  assign sweep_cnt = sweep_q;
  assign err_cnt   = err_q;
  assign err_stb   = stb_q;

endmodule
`default_nettype wire

// File: tb/tb_led_scan_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_scan_monitor
// Description : Self-checking bench for led_scan_monitor. Two instances share
//               the stimulus: one with 16-bit counters and one with 2-bit
//               counters so saturation is reachable. Each table row holds a
//               frame and the hand-derived outputs it must produce two edges
//               after capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_scan_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] led_in;
  logic       sample_en;

  logic        lk_a, dir_a, stb_a;
  logic [3:0]  pos_a;
  logic [15:0] sw_a, er_a;
  logic        lk_b, dir_b, stb_b;
  logic [3:0]  pos_b;
  logic [1:0]  sw_b, er_b;

  led_scan_monitor #(.LOCK_FRAMES(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .led_in(led_in), .sample_en(sample_en),
    .locked(lk_a), .pos2(pos_a), .dir(dir_a),
    .sweep_cnt(sw_a), .err_cnt(er_a), .err_stb(stb_a)
  );

  led_scan_monitor #(.LOCK_FRAMES(4), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .led_in(led_in), .sample_en(sample_en),
    .locked(lk_b), .pos2(pos_b), .dir(dir_b),
    .sweep_cnt(sw_b), .err_cnt(er_b), .err_stb(stb_b)
  );

  always #5 clk = ~clk;

  int edges = 0;
  always @(posedge clk) edges <= edges + 1;

  typedef struct {
    logic [7:0] led;
    logic       en;
    logic       lk;
    int         p;
    logic       d;
    int         sw;
    int         er;
    logic       stb;
  } vec_t;

  typedef struct {
    int   due;
    int   row;
    vec_t v;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic add(input logic [7:0] led, input logic en, input logic lk,
                     input int p, input logic d, input int sw, input int er,
                     input logic stb);
    vec_t v;
    v.led = led; v.en = en; v.lk = lk; v.p = p; v.d = d;
    v.sw = sw; v.er = er; v.stb = stb;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input vec_t e);
    chk({tag, " a.locked"},    32'(lk_a),  32'(e.lk));
    chk({tag, " a.pos2"},      32'(pos_a), 32'(e.p));
    chk({tag, " a.dir"},       32'(dir_a), 32'(e.d));
    chk({tag, " a.sweep_cnt"}, 32'(sw_a),  32'(e.sw));
    chk({tag, " a.err_cnt"},   32'(er_a),  32'(e.er));
    chk({tag, " a.err_stb"},   32'(stb_a), 32'(e.stb));
    chk({tag, " b.locked"},    32'(lk_b),  32'(e.lk));
    chk({tag, " b.pos2"},      32'(pos_b), 32'(e.p));
    chk({tag, " b.dir"},       32'(dir_b), 32'(e.d));
    chk({tag, " b.sweep_cnt"}, 32'(sw_b),  32'(sat(e.sw, 3)));
    chk({tag, " b.err_cnt"},   32'(er_b),  32'(sat(e.er, 3)));
    chk({tag, " b.err_stb"},   32'(stb_b), 32'(e.stb));
  endtask

  // Called at each negedge: compare the entry whose result is due now.
  task automatic service();
    sb_t s;
    if (sb.size() > 0 && sb[0].due == edges) begin
      s = sb.pop_front();
      check_all($sformatf("row%0d", s.row), s.v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t zero;
    sb_t  s;
    zero.led = 8'h00; zero.en = 1'b0; zero.lk = 1'b0; zero.p = 0;
    zero.d = 1'b0; zero.sw = 0; zero.er = 0; zero.stb = 1'b0;

    // ---------------- vector table: led, en, locked, pos2, dir, sweep, err, stb
    // Acquire and lock on an upward sweep
    add(8'h01, 1, 0,  0, 0, 0, 0, 0);
    add(8'h03, 1, 0,  1, 0, 0, 0, 0);
    add(8'h06, 1, 0,  3, 0, 0, 0, 0);
    add(8'h0C, 1, 0,  5, 0, 0, 0, 0);
    add(8'h18, 1, 1,  7, 0, 0, 0, 0);
    // Locked sweep up to the top end and back
    add(8'h30, 1, 1,  9, 0, 0, 0, 0);
    add(8'h20, 1, 1, 10, 0, 0, 0, 0);
    add(8'h40, 1, 1, 12, 0, 0, 0, 0);
    add(8'hC0, 1, 1, 13, 0, 0, 0, 0);
    add(8'h80, 1, 1, 14, 0, 0, 0, 0);
    add(8'hC0, 1, 1, 13, 1, 1, 0, 0);
    add(8'h60, 1, 1, 11, 1, 1, 0, 0);
    add(8'h30, 1, 1,  9, 1, 1, 0, 0);
    add(8'h18, 1, 1,  7, 1, 1, 0, 0);
    add(8'h0C, 1, 1,  5, 1, 1, 0, 0);
    add(8'h06, 1, 1,  3, 1, 1, 0, 0);
    // Repeated frame while locked: stalls only
    for (int k = 0; k < 10; k++) add(8'h06, 1, 1, 3, 1, 1, 0, 0);
    // No strobe: bus content ignored
    add(8'hFF, 0, 1,  3, 1, 1, 0, 0);
    add(8'h0C, 1, 1,  5, 0, 2, 0, 0);
    add(8'h18, 1, 1,  7, 0, 2, 0, 0);
    // Illegal frame while locked, then illegal frames while unlocked
    add(8'h81, 1, 0,  7, 0, 2, 1, 1);
    add(8'h00, 1, 0,  7, 0, 2, 1, 1);
    add(8'h05, 1, 0,  7, 0, 2, 1, 1);
    add(8'h07, 1, 0,  7, 0, 2, 1, 1);
    // Re-acquire: stall, legal jump reloads reference, reversal on lock frame
    add(8'h18, 1, 0,  7, 0, 2, 1, 0);
    add(8'h18, 1, 0,  7, 0, 2, 1, 0);
    add(8'h80, 1, 0,  7, 0, 2, 1, 1);
    add(8'hC0, 1, 0, 13, 1, 2, 1, 0);
    add(8'h40, 1, 0, 12, 1, 2, 1, 0);
    add(8'h60, 1, 0, 11, 1, 2, 1, 0);
    add(8'h40, 1, 1, 12, 0, 2, 1, 0);
    // Down to 7, then a jump to 13 while locked
    add(8'h20, 1, 1, 10, 1, 3, 1, 0);
    add(8'h10, 1, 1,  8, 1, 3, 1, 0);
    add(8'h18, 1, 1,  7, 1, 3, 1, 0);
    add(8'hC0, 1, 0,  7, 1, 3, 2, 1);
    // Three moves, then an error where the fourth would have locked
    add(8'h18, 1, 0,  7, 1, 3, 2, 0);
    add(8'h30, 1, 0,  9, 0, 3, 2, 0);
    add(8'h60, 1, 0, 11, 0, 3, 2, 0);
    add(8'hC0, 1, 0, 13, 0, 3, 2, 0);
    add(8'h03, 1, 0, 13, 0, 3, 2, 1);
    add(8'hFF, 1, 0, 13, 0, 3, 2, 1);
    // Re-lock from the bottom end
    add(8'h01, 1, 0,  0, 0, 3, 2, 0);
    add(8'h02, 1, 0,  2, 0, 3, 2, 0);
    add(8'h06, 1, 0,  3, 0, 3, 2, 0);
    add(8'h04, 1, 0,  4, 0, 3, 2, 0);
    add(8'h0C, 1, 1,  5, 0, 3, 2, 0);
    // Push the narrow counters into saturation
    add(8'h00, 1, 0,  5, 0, 3, 3, 1);
    add(8'h0C, 1, 0,  5, 0, 3, 3, 0);
    add(8'h18, 1, 0,  7, 0, 3, 3, 0);
    add(8'h30, 1, 0,  9, 0, 3, 3, 0);
    add(8'h60, 1, 0, 11, 0, 3, 3, 0);
    add(8'hC0, 1, 1, 13, 0, 3, 3, 0);
    add(8'h40, 1, 1, 12, 1, 4, 3, 0);
    add(8'h01, 1, 0, 12, 1, 4, 4, 1);

    // ---------------- reset state
    rst = 1'b1; sample_en = 1'b0; led_in = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_all("reset", zero);

    // ---------------- table, back-to-back strobes through the scoreboard
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      service();
      led_in    = vecs[i].led;
      sample_en = vecs[i].en;
      s.due = edges + 3;
      s.row = i;
      s.v   = vecs[i];
      sb.push_back(s);
    end
    @(negedge clk);
    service();
    sample_en = 1'b0;
    led_in    = 8'h00;
    for (int k = 0; k < 8 && sb.size() > 0; k++) begin
      @(negedge clk);
      service();
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end

    // ---------------- reset while a frame sits in S1, strobe held during reset
    @(negedge clk);
    led_in = 8'h80; sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b1; led_in = 8'h01;
    rst = 1'b1;
    #1 check_all("async_rst", zero);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; sample_en = 1'b0; led_in = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_all($sformatf("post_rst%0d", k), zero);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
